// File: rtl/ora_seq_checker_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ora_seq_checker_pkg : shared types and packet field positions
// rev 1.0
// ------------------------------------------------------------------
package ora_seq_checker_pkg;

   localparam int ID_WIDTH = 8;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_MISROUTE   = 2'd1,
      ERR_UNKNOWN_ID = 2'd2,
      ERR_SEQ        = 2'd3
   } err_code_t;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } chk_state_t;

   // Packet layout, MSB first: {src[na], dst[na], id[8], seq[rest]}
   function automatic int seq_width(input int width, input int na);
      return width - 2 * na - ID_WIDTH;
   endfunction

   function automatic int id_pos(input int width, input int na);
      return width - 2 * na - ID_WIDTH;
   endfunction

   function automatic int dst_pos(input int width, input int na);
      return width - 2 * na;
   endfunction

   function automatic int src_pos(input int width, input int na);
      return width - na;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ora_seq_checker_if.sv
`default_nettype none
// ------------------------------------------------------------------
// ora_seq_checker_if : valid/ready packet channel into the checker
// rev 1.0
// ------------------------------------------------------------------
interface ora_seq_checker_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] i0_data_in;
   logic             i0_valid_in;
   logic             i0_ready_out;

   modport master (output i0_data_in, output i0_valid_in, input i0_ready_out);
   modport slave  (input i0_data_in, input i0_valid_in, output i0_ready_out);
endinterface
`default_nettype wire

// File: rtl/ora_seq_checker_table.sv
`default_nettype none
// ------------------------------------------------------------------
// ora_seq_checker_table : per-ID expected sequence and completion count
// rev 1.0
// ------------------------------------------------------------------
module ora_seq_checker_table #(
   parameter int NUM_SRC    = 4,
   parameter int SW         = 16,
   parameter int IDX_W      = 2,
   parameter int DONE_COUNT = 1000
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [IDX_W-1:0] i_idx,
   output logic      [SW-1:0]    o_exp_seq,
   input  wire logic             i_we,
   input  wire logic             i_clean,
   input  wire logic [SW-1:0]    i_seq,
   output logic                  o_done
);
   localparam int            CW     = $clog2(DONE_COUNT + 1);
   localparam logic [CW-1:0] C_DONE = CW'(DONE_COUNT);

   logic [SW-1:0]      r_exp [NUM_SRC];
   logic [CW-1:0]      r_cnt [NUM_SRC];
   logic [NUM_SRC-1:0] w_at_done;

   // Read and write share one stage, so a same-ID packet in the next
   // cycle always reads the value written by its predecessor.
   assign o_exp_seq = r_exp[i_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            r_exp[i] <= SW'(1);
            r_cnt[i] <= '0;
         end
      end else if (i_we) begin
         r_exp[i_idx] <= i_seq + SW'(1);
         if (i_clean && (r_cnt[i_idx] != C_DONE)) begin
            r_cnt[i_idx] <= r_cnt[i_idx] + CW'(1);
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_SRC; g++) begin : g_done
         assign w_at_done[g] = (r_cnt[g] == C_DONE);
      end
   endgenerate

   // Counts saturate and only clear on reset, so done is inherently sticky.
   assign o_done = &w_at_done;

endmodule
`default_nettype wire

// File: rtl/ora_seq_checker.sv
`default_nettype none
// ------------------------------------------------------------------
// ora_seq_checker : NoC sink checking routing and per-ID sequence order
// rev 1.0
// ------------------------------------------------------------------
module ora_seq_checker
   import ora_seq_checker_pkg::*;
#(
   parameter int I0_WIDTH     = 32,
   parameter int N            = 16,
   parameter int N_ADDR_WIDTH = $clog2(N),
   parameter int NODE         = 15,
   parameter int NUM_SRC      = 4,
   parameter int DONE_COUNT   = 1000,
   parameter int STALL_PERIOD = 0,
   parameter int STALL_CYCLES = 2
) (
   input  wire logic         clk,
   input  wire logic         rst,
   ora_seq_checker_if.slave  i0,
   output logic              err_out,
   output logic [1:0]        err_code_out,
   output logic [15:0]       err_count_out,
   output logic [31:0]       pkt_count_out,
   output logic              done
);
   localparam int NA      = N_ADDR_WIDTH;
   localparam int SW      = seq_width(I0_WIDTH, NA);
   localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int SRC_POS = src_pos(I0_WIDTH, NA);
   localparam int DST_POS = dst_pos(I0_WIDTH, NA);
   localparam int ID_POS  = id_pos(I0_WIDTH, NA);

   localparam logic [31:0]   C_STALL_PERIOD = STALL_PERIOD;
   localparam logic [31:0]   C_STALL_CYCLES = STALL_CYCLES;
   localparam bit            C_STALL_EN     = (STALL_PERIOD > 0);
   localparam logic [NA-1:0] C_NODE         = NA'(NODE);
   localparam logic [7:0]    C_NUM_SRC      = 8'(NUM_SRC);

   chk_state_t    r_state;
   logic          r_ready;
   logic [31:0]   r_acc_cnt;
   logic [31:0]   r_stall_cnt;
   logic          w_xfer;
   logic          w_unused_src;

   logic          r_s1_vld, r_s2_vld;
   logic [NA-1:0] r_s1_dst, r_s2_dst;
   logic [7:0]    r_s1_id,  r_s2_id;
   logic [SW-1:0] r_s1_seq, r_s2_seq;

   err_code_t     w_code;
   logic [SW-1:0] w_exp_seq;
   logic          w_tbl_we, w_tbl_clean;
   logic          r_err;
   err_code_t     r_err_code;
   logic [15:0]   r_err_count;
   logic [31:0]   r_pkt_count;

   assign w_xfer          = i0.i0_valid_in & r_ready;
   assign i0.i0_ready_out = r_ready;
   assign w_unused_src    = ^i0.i0_data_in[SRC_POS +: NA];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_INIT;
         r_ready     <= 1'b0;
         r_acc_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_state   <= ST_RUN;
               r_ready   <= 1'b1;
               r_acc_cnt <= '0;
            end
            ST_RUN: begin
               if (C_STALL_EN && w_xfer) begin
                  if (r_acc_cnt == C_STALL_PERIOD - 32'd1) begin
                     r_state     <= ST_STALL;
                     r_ready     <= 1'b0;
                     r_acc_cnt   <= '0;
                     r_stall_cnt <= '0;
                  end else begin
                     r_acc_cnt <= r_acc_cnt + 32'd1;
                  end
               end
            end
            ST_STALL: begin
               if (r_stall_cnt == C_STALL_CYCLES - 32'd1) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end else begin
                  r_stall_cnt <= r_stall_cnt + 32'd1;
               end
            end
            default: begin
               r_state <= ST_INIT;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_vld    <= 1'b0;
         r_s1_dst    <= '0;
         r_s1_id     <= '0;
         r_s1_seq    <= '0;
         r_s2_vld    <= 1'b0;
         r_s2_dst    <= '0;
         r_s2_id     <= '0;
         r_s2_seq    <= '0;
         r_pkt_count <= '0;
      end else begin
         r_s1_vld <= w_xfer;
         if (w_xfer) begin
            r_s1_dst    <= i0.i0_data_in[DST_POS +: NA];
            r_s1_id     <= i0.i0_data_in[ID_POS +: 8];
            r_s1_seq    <= i0.i0_data_in[SW-1:0];
            r_pkt_count <= r_pkt_count + 32'd1;
         end
         r_s2_vld <= r_s1_vld;
         r_s2_dst <= r_s1_dst;
         r_s2_id  <= r_s1_id;
         r_s2_seq <= r_s1_seq;
      end
   end

   // Priority order: routing, then ID range, then sequence continuity.
   always_comb begin
      w_code = ERR_NONE;
      if (r_s2_dst != C_NODE) begin
         w_code = ERR_MISROUTE;
      end else if (r_s2_id >= C_NUM_SRC) begin
         w_code = ERR_UNKNOWN_ID;
      end else if (r_s2_seq != w_exp_seq) begin
         w_code = ERR_SEQ;
      end
   end

   assign w_tbl_we    = r_s2_vld && ((w_code == ERR_NONE) || (w_code == ERR_SEQ));
   assign w_tbl_clean = r_s2_vld && (w_code == ERR_NONE);

   ora_seq_checker_table #(
      .NUM_SRC    (NUM_SRC),
      .SW         (SW),
      .IDX_W      (IDX_W),
      .DONE_COUNT (DONE_COUNT)
   ) u_table (
      .clk       (clk),
      .rst       (rst),
      .i_idx     (r_s2_id[IDX_W-1:0]),
      .o_exp_seq (w_exp_seq),
      .i_we      (w_tbl_we),
      .i_clean   (w_tbl_clean),
      .i_seq     (r_s2_seq),
      .o_done    (done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err       <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_err_count <= '0;
      end else if (r_s2_vld && (w_code != ERR_NONE)) begin
         r_err <= 1'b1;
         if (!r_err) begin
            r_err_code <= w_code;
         end
         if (r_err_count != 16'hFFFF) begin
            r_err_count <= r_err_count + 16'd1;
         end
      end
   end

   assign err_out       = r_err;
   assign err_code_out  = r_err_code;
   assign err_count_out = r_err_count;
   assign pkt_count_out = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_ora_seq_checker.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ora_seq_checker : directed stimulus against a behavioural sink model
// rev 1.0
// ------------------------------------------------------------------
module tb_ora_seq_checker;
   localparam int W     = 32;
   localparam int NODE  = 15;
   localparam int NSRC  = 4;
   localparam int DC    = 4;
   localparam int SP    = 3;
   localparam int SC    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        err_out;
   logic [1:0]  err_code_out;
   logic [15:0] err_count_out;
   logic [31:0] pkt_count_out;
   logic        done;

   int tests_run    = 0;
   int tests_failed = 0;
   bit chk_en       = 1'b0;

   ora_seq_checker_if #(.WIDTH(W)) bus ();

   ora_seq_checker #(
      .I0_WIDTH     (W),
      .N            (16),
      .N_ADDR_WIDTH (4),
      .NODE         (NODE),
      .NUM_SRC      (NSRC),
      .DONE_COUNT   (DC),
      .STALL_PERIOD (SP),
      .STALL_CYCLES (SC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i0            (bus),
      .err_out       (err_out),
      .err_code_out  (err_code_out),
      .err_count_out (err_count_out),
      .pkt_count_out (pkt_count_out),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Behavioural model: apply each accepted packet's rules at once, then
   // delay the error/done view by two edges; packet count is immediate.
   typedef struct {
      bit err;
      int code;
      int ecnt;
      bit done;
   } snap_t;

   snap_t       m_now, m_p1, m_p2, m_vis;
   int          m_exp [NSRC];
   int          m_cnt [NSRC];
   logic [31:0] m_pkt;
   bit          m_rdy;
   int          m_phase;
   int          m_acc;
   int          m_st;
   bit          m_xfer;
   bit          rdy_s;

   function automatic void check(input string name, input longint act, input longint exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_now   = '{1'b0, 0, 0, 1'b0};
      m_p1    = m_now;
      m_p2    = m_now;
      m_vis   = m_now;
      m_pkt   = '0;
      m_rdy   = 1'b0;
      m_phase = 0;
      m_acc   = 0;
      m_st    = 0;
      for (int i = 0; i < NSRC; i++) begin
         m_exp[i] = 1;
         m_cnt[i] = 0;
      end
   endfunction

   function automatic void model_pkt(input logic [31:0] d);
      int dst, id, seq, code;
      bit all;
      dst  = int'(d[27:24]);
      id   = int'(d[23:16]);
      seq  = int'(d[15:0]);
      code = 0;
      if (dst != NODE) begin
         code = 1;
      end else if (id >= NSRC) begin
         code = 2;
      end else if (seq != m_exp[id]) begin
         code = 3;
         m_exp[id] = (seq + 1) % 65536;
      end else begin
         m_exp[id] = (seq + 1) % 65536;
         if (m_cnt[id] < DC) m_cnt[id]++;
      end
      if (code != 0) begin
         if (!m_now.err) m_now.code = code;
         m_now.err = 1'b1;
         if (m_now.ecnt < 65535) m_now.ecnt++;
      end
      all = 1'b1;
      for (int i = 0; i < NSRC; i++) if (m_cnt[i] != DC) all = 1'b0;
      m_now.done = all;
   endfunction

   always @(negedge clk) rdy_s = bus.i0_ready_out;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_reset();
      end else begin
         m_xfer = bus.i0_valid_in && rdy_s;
         if (m_xfer) begin
            model_pkt(bus.i0_data_in);
            m_pkt = m_pkt + 32'd1;
         end
         m_vis = m_p2;
         m_p2  = m_p1;
         m_p1  = m_now;
         // Ready pattern: one dead cycle after reset, then SP accepts, SC stalls.
         case (m_phase)
            0: begin m_phase = 1; m_rdy = 1'b1; m_acc = 0; end
            1: begin
               if (m_xfer) begin
                  m_acc++;
                  if (m_acc == SP) begin m_phase = 2; m_rdy = 1'b0; m_st = 0; end
               end
            end
            default: begin
               m_st++;
               if (m_st == SC) begin m_phase = 1; m_rdy = 1'b1; m_acc = 0; end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ready",     bus.i0_ready_out, m_rdy);
         check("pkt_count", pkt_count_out,    m_pkt);
         check("err_out",   err_out,          m_vis.err);
         check("err_code",  err_code_out,     m_vis.code);
         check("err_count", err_count_out,    m_vis.ecnt);
         check("done",      done,             m_vis.done);
      end
   end

   task automatic send(input int id, input int seq, input int dst = NODE);
      int g;
      g = 0;
      bus.i0_data_in  = {4'd2, dst[3:0], id[7:0], seq[15:0]};
      bus.i0_valid_in = 1'b1;
      while (!bus.i0_ready_out && g < 40) begin
         @(negedge clk);
         g++;
      end
      if (g >= 40) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout: ready low for %0d cycles, required 1", g);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.i0_valid_in = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      bus.i0_valid_in = 1'b0;
      #1 rst = 1'b0;
      @(negedge clk);
      check("lit_rst_ready", bus.i0_ready_out, 0);
      check("lit_rst_pkt",   pkt_count_out,    0);
      check("lit_rst_done",  done,             0);
      check("lit_rst_err",   err_out,          0);
      #1 rst = 1'b1;
      check("lit_release_ready", bus.i0_ready_out, 0);
      @(negedge clk);
      check("lit_run_ready", bus.i0_ready_out, 1);
   endtask

   bit exp_pat [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   bit hist    [10];

   initial begin
      int seqn;
      bus.i0_valid_in = 1'b0;
      bus.i0_data_in  = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("lit_init_ready", bus.i0_ready_out, 0);
      check("lit_init_pkt",   pkt_count_out,    0);
      #1 rst = 1'b1;
      @(negedge clk);

      // In-order stream then a misrouted packet
      for (int s = 1; s <= 5; s++) send(0, s);
      idle(4);
      check("lit_g1_pkt",  pkt_count_out, 5);
      check("lit_g1_err",  err_out,       0);
      check("lit_g1_code", err_code_out,  0);
      send(0, 6, 3);
      idle(4);
      check("lit_misroute_code", err_code_out,  1);
      check("lit_misroute_cnt",  err_count_out, 1);
      send(0, 6);
      idle(4);
      check("lit_misroute_nochange", err_count_out, 1);

      // Unknown ID, then a sequence error keeps the first code
      do_reset();
      for (int s = 1; s <= 5; s++) send(0, s);
      send(7, 1);
      idle(4);
      check("lit_unknown_code", err_code_out,  2);
      check("lit_unknown_cnt",  err_count_out, 1);
      send(0, 9);
      idle(4);
      check("lit_first_code_kept", err_code_out,  2);
      check("lit_second_cnt",      err_count_out, 2);

      // Gap with resync, then sequence wrap
      do_reset();
      send(1, 1); send(1, 2); send(1, 4); send(1, 5);
      idle(4);
      check("lit_seq_code", err_code_out,  3);
      check("lit_seq_cnt",  err_count_out, 1);
      send(3, 16'hFFFF); send(3, 0); send(3, 1);
      idle(4);
      check("lit_wrap_cnt", err_count_out, 2);

      // Forced stall pattern with valid held high
      do_reset();
      seqn = 1;
      for (int c = 0; c < 10; c++) begin
         bus.i0_data_in  = {4'd2, 4'd15, 8'd2, 16'(seqn)};
         bus.i0_valid_in = 1'b1;
         hist[c] = bus.i0_ready_out;
         @(negedge clk);
         if (hist[c]) seqn++;
      end
      idle(4);
      for (int c = 0; c < 10; c++) check($sformatf("lit_stall_ready_%0d", c), hist[c], exp_pat[c]);
      check("lit_stall_pkt", pkt_count_out, 6);
      check("lit_stall_err", err_out,       0);

      // Completion, reset mid-stream, then completion again
      do_reset();
      for (int s = 1; s <= DC; s++) for (int id = 0; id < 3; id++) send(id, s);
      idle(4);
      check("lit_done_partial", done, 0);
      send(3, 1);
      do_reset();
      for (int s = 1; s <= DC; s++) for (int id = 0; id < NSRC; id++) send(id, s);
      check("lit_done_latency", done, 0);
      idle(4);
      check("lit_done_full", done,          1);
      check("lit_done_pkt",  pkt_count_out, 16);
      check("lit_done_err",  err_out,       0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      tests_run++;
      tests_failed++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
